// File: rtl/mem_arbiter.sv
`default_nettype none
//==============================================================================
// mem_arbiter : round-robin CPU/DMA arbiter for a single registered memory port
// Revision    : 1.0
//==============================================================================
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpuReq,
  input  logic        cpuWe,
  input  logic [15:0] cpuAddr,
  input  logic [15:0] cpuWData,
  output logic        cpuAck,
  output logic [15:0] cpuRData,
  output logic        clkHold,
  input  logic        dmaReq,
  input  logic        dmaWe,
  input  logic [15:0] dmaAddr,
  input  logic [15:0] dmaWData,
  output logic        dmaAck,
  output logic [15:0] dmaRData,
  output logic [15:0] memAddr,
  output logic        memRe,
  output logic        memWe,
  output logic [15:0] memWBus,
  input  logic [15:0] memRBus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] C_LAT_LOAD = 4'(READ_LATENCY - 1);
  localparam logic       C_OWN_CPU  = 1'b0;
  localparam logic       C_OWN_DMA  = 1'b1;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wbus_q, mem_wbus_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dma_ack_q, dma_ack_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] dma_rdata_q, dma_rdata_d;

  logic        w_req_any;
  logic        w_grant_dma;
  logic        w_req_we;
  logic [15:0] w_req_addr;
  logic [15:0] w_req_wdata;

  // On a tie the requester that did not win last time takes the port.
  assign w_req_any   = cpuReq | dmaReq;
  assign w_grant_dma = dmaReq & (~cpuReq | (last_grant_q == C_OWN_CPU));
  assign w_req_we    = w_grant_dma ? dmaWe    : cpuWe;
  assign w_req_addr  = w_grant_dma ? dmaAddr  : cpuAddr;
  assign w_req_wdata = w_grant_dma ? dmaWData : cpuWData;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    mem_addr_d   = 16'h0000;
    mem_wbus_d   = 16'h0000;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;

    // Memory-side outputs are computed from the next state so they appear
    // registered in the same cycle the FSM enters that state.
    unique case (state_q)
      S_IDLE: begin
        if (w_req_any) begin
          owner_d      = w_grant_dma;
          last_grant_d = w_grant_dma;
          addr_d       = w_req_addr;
          wdata_d      = w_req_wdata;
          mem_addr_d   = w_req_addr;
          if (w_req_we) begin
            state_d    = S_WRITE;
            mem_we_d   = 1'b1;
            mem_wbus_d = w_req_wdata;
          end else begin
            state_d  = S_READ;
            cnt_d    = C_LAT_LOAD;
            mem_re_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (owner_q == C_OWN_DMA) begin
            dma_rdata_d = memRBus;
            dma_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = memRBus;
            cpu_ack_d   = 1'b1;
          end
        end else begin
          cnt_d      = cnt_q - 4'd1;
          mem_re_d   = 1'b1;
          mem_addr_d = addr_q;
        end
      end
      S_WRITE: begin
        state_d = S_DONE;
        if (owner_q == C_OWN_DMA) begin
          dma_ack_d = 1'b1;
        end else begin
          cpu_ack_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= C_OWN_CPU;
      last_grant_q <= C_OWN_DMA;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      cnt_q        <= 4'd0;
      mem_addr_q   <= 16'h0000;
      mem_wbus_q   <= 16'h0000;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rdata_q  <= 16'h0000;
      dma_rdata_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wbus_q   <= mem_wbus_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign memAddr  = mem_addr_q;
  assign memWBus  = mem_wbus_q;
  assign memRe    = mem_re_q;
  assign memWe    = mem_we_q;
  assign cpuAck   = cpu_ack_q;
  assign dmaAck   = dma_ack_q;
  assign cpuRData = cpu_rdata_q;
  assign dmaRData = dma_rdata_q;
  assign clkHold  = rst & cpuReq & ~cpu_ack_q;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: the CPU control sequencer and a DMA/debug loader that preloads or inspects memory while the CPU runs.
- Each requester uses a req/ack handshake.
- The arbiter sequences every access through a small state machine and drives the memory control lines.
- It raises clkHold to stall the CPU whenever a CPU access is pending.

Parameters:
READ_LATENCY, 1, cycles memRe/memAddr must be held before memRBus is valid; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-low
cpuReq  in  1  CPU access request; held until cpuAck
cpuWe  in  1  1=write, 0=read; stable while cpuReq
cpuAddr  in  16  CPU address; stable while cpuReq
cpuWData  in  16  CPU write data
cpuAck  out  1  one-cycle completion pulse
cpuRData  out  16  CPU read data, valid with cpuAck, held until next CPU read completes
clkHold  out  1  CPU stall
dmaReq  in  1  DMA request
dmaWe  in  1  DMA write enable
dmaAddr  in  16  DMA address
dmaWData  in  16  DMA write data
dmaAck  out  1  DMA completion pulse
dmaRData  out  16  DMA read data, same rules as cpuRData
memAddr  out  16  memory address
memRe  out  1  memory read enable
memWe  out  1  memory write enable
memWBus  out  16  memory write data
memRBus  in  16  memory read data

Behaviour:
- Reset, sampled at posedge when rst=0:
  - State goes to IDLE; in-flight access is abandoned, with no ack.
  - Registered outputs (memAddr, memRe, memWe, memWBus, cpuAck, dmaAck, cpuRData, dmaRData) become 0.
  - lastGrant becomes DMA.
- States: IDLE, READ, WRITE, DONE. All memory-side outputs are registered.
- IDLE: samples cpuReq/dmaReq.
  - Neither set: stay in IDLE.
  - One set: grant it.
  - Both set: grant the requester that is not lastGrant (round-robin), so CPU wins the first tie after reset.
  - On grant: latch owner, addr, we and wdata; update lastGrant. Next state is WRITE if we=1, else READ with the latency counter loaded to READ_LATENCY-1.
- READ:
  - memRe=1, memAddr=latched addr, memWe=0.
  - Stay until the counter hits 0, then go to DONE.
  - memRBus is captured into the owner's RData at the posedge that leaves READ.
- WRITE:
  - memWe=1, memAddr=latched addr, memWBus=latched wdata, memRe=0.
  - Exactly one cycle, then DONE.
- DONE:
  - Owner's ack=1 for this one cycle; memRe=memWe=0; memAddr and memWBus return to 0.
  - Requests are ignored, because the owner's req is still high.
  - Next state is IDLE.
- Latency from first req-high cycle in IDLE:
  - Read: ack at cycle +READ_LATENCY+1.
  - Write: ack at cycle +2.
  - Minimum spacing between grants is READ_LATENCY+2 cycles for a read and 3 for a write.
- Requesters may drop or re-raise req only in the cycle after their ack. A req that drops before ack is a protocol error; it is ignored and the access completes.
- clkHold = rst & cpuReq & ~cpuAck (combinational). It is high from the first CPU req cycle through the last cycle before ack.
- Invariant: memRe & memWe is never 1. A non-owner ack never pulses.
- Address/data are 16 bits with no wrap or arithmetic. The 0xFFFF address is a normal access.

Test Plan:
1. Hold rst=0 for 3 cycles with cpuReq=dmaReq=1, then release → all outputs 0 during reset; first grant goes to CPU; clkHold=0 while rst=0.
2. With READ_LATENCY=1 and mem[0x0010]=0xBEEF, pulse a CPU read at 0x0010 → memRe=1 with memAddr=0x0010 at T+1; cpuAck=1 and cpuRData=0xBEEF at T+2; clkHold=1 at T..T+1 and 0 at T+2.
3. DMA write 0x0200←0x1234, then CPU read 0x0200 → memWe=1 for exactly one cycle with memWBus=0x1234; dmaAck at T+2; the CPU read returns 0x1234; clkHold stays 0 during the DMA write.
4. cpuReq and dmaReq held continuously, all writes → grant order CPU, DMA, CPU, DMA; acks spaced 3 cycles apart; memRe and memWe never both high.
5. With READ_LATENCY=3, do a DMA read at 0xFFFF (mem=0xA5A5) → memRe high for exactly 3 cycles; dmaAck and dmaRData=0xA5A5 on the 4th cycle after grant; cpuRData unchanged.
6. Drive rst=0 during the second READ cycle of a CPU read → next cycle memRe=0 and state IDLE; no cpuAck; cpuRData=0; after release a re-issued read completes normally.
